// File: rtl/capture_sequencer.sv
//------------------------------------------------------------------------------
// capture_sequencer
//
// Sequences one oscilloscope acquisition. It first fills PRETRIGGER samples of
// history into the capture RAM. It then enables the external trigger block and
// keeps overwriting the RAM circularly until a trigger arrives. A trigger can be
// a real edge, or a forced timeout when autoMode is set. After the trigger it
// writes the post-trigger tail of DEPTH-PRETRIGGER samples. When the tail is
// complete it raises captureDone and holds the buffer until the readout side
// pulses readDone.
//
// Ports
//   clock, reset       system clock; synchronous active-high reset
//   arm                pulse, starts an acquisition (honoured in IDLE only)
//   abort              pulse, returns to IDLE from any state
//   autoMode           force a trigger after AUTO_TIMEOUT armed samples
//   continuous         re-arm automatically after readDone
//   dataReady, dataIn  ADC sample strobe and sample value
//   isTriggered        trigger pulse from the rising-edge trigger block
//   triggerDisable     to the trigger block; low only while ARMED
//   writeEnable,
//   writeAddress,
//   writeData          capture RAM write port (one cycle after dataReady)
//   triggerAddress     RAM address of the first sample on/after the trigger
//   autoTriggered      the current capture was ended by timeout
//   captureDone        level, high while the buffer waits for readout
//   readDone           pulse from readout, buffer consumed
//------------------------------------------------------------------------------
module capture_sequencer #(
    parameter int DATA_BITS    = 12,
    parameter int ADDR_BITS    = 10,
    parameter int PRETRIGGER   = 256,
    parameter int AUTO_TIMEOUT = 4095
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 autoMode,
    input  logic                 continuous,
    input  logic                 dataReady,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 isTriggered,
    output logic                 triggerDisable,
    output logic                 writeEnable,
    output logic [ADDR_BITS-1:0] writeAddress,
    output logic [DATA_BITS-1:0] writeData,
    output logic [ADDR_BITS-1:0] triggerAddress,
    output logic                 autoTriggered,
    output logic                 captureDone,
    input  logic                 readDone
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_BITS-1:0] PRE_LAST = ADDR_BITS'(PRETRIGGER - 1);
    localparam logic [ADDR_BITS-1:0] POST_LEN = ADDR_BITS'(DEPTH - PRETRIGGER);
    localparam logic [15:0]          TMO_ONE  = 16'd1;
    localparam logic [15:0]          TMO_LIM  = 16'(AUTO_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        PREFILL,
        ARMED,
        POST,
        DONE
    } state_t;

    state_t                 state_q,          state_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q,         wr_ptr_d;
    logic [ADDR_BITS-1:0]   pre_count_q,      pre_count_d;
    logic [ADDR_BITS-1:0]   post_count_q,     post_count_d;
    logic [15:0]            timeout_q,        timeout_d;
    logic                   write_enable_q,   write_enable_d;
    logic [ADDR_BITS-1:0]   write_address_q,  write_address_d;
    logic [DATA_BITS-1:0]   write_data_q,     write_data_d;
    logic [ADDR_BITS-1:0]   trigger_address_q, trigger_address_d;
    logic                   auto_triggered_q, auto_triggered_d;
    logic                   trigger_disable_q, trigger_disable_d;
    logic                   capture_done_q,   capture_done_d;

    logic take;       // current sample goes to RAM
    logic restart;    // start a fresh acquisition (from arm or continuous re-arm)
    logic fire_auto;  // timeout reached with auto mode enabled
    logic fire;       // real or forced trigger while ARMED

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d           = state_q;
        wr_ptr_d          = wr_ptr_q;
        pre_count_d       = pre_count_q;
        post_count_d      = post_count_q;
        timeout_d         = timeout_q;
        write_enable_d    = 1'b0;
        write_address_d   = write_address_q;
        write_data_d      = write_data_q;
        trigger_address_d = trigger_address_q;
        auto_triggered_d  = auto_triggered_q;
        take              = 1'b0;
        restart           = 1'b0;
        fire_auto         = autoMode && (timeout_q == TMO_LIM);
        fire              = 1'b0;

        if (abort) begin
            // The write strobe stays at its default of 0, which cancels any
            // in-flight write.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    restart = arm;
                end
                PREFILL: begin
                    // isTriggered is deliberately ignored until the history is full.
                    if (dataReady) begin
                        take        = 1'b1;
                        pre_count_d = pre_count_q + ADDR_ONE;
                        if (pre_count_q == PRE_LAST) begin
                            state_d = ARMED;
                        end
                    end
                end
                ARMED: begin
                    fire = isTriggered || fire_auto;
                    if (dataReady) begin
                        take = 1'b1;
                        // Saturate so a long manual-mode wait never wraps into a
                        // spurious timeout.
                        if (timeout_q != '1) begin
                            timeout_d = timeout_q + TMO_ONE;
                        end
                    end
                    if (fire) begin
                        state_d           = POST;
                        post_count_d      = '0;
                        // A sample that arrives with the trigger still belongs to
                        // the pre-trigger history, so the trigger point is the
                        // address after it.
                        trigger_address_d = dataReady ? (wr_ptr_q + ADDR_ONE) : wr_ptr_q;
                        // A real edge wins over a timeout in the same cycle.
                        auto_triggered_d  = !isTriggered;
                    end
                end
                POST: begin
                    // Leave only after the last tail write has been issued, so
                    // the RAM strobe never overlaps DONE. Anything arriving in
                    // this final cycle is dropped.
                    if (post_count_q == POST_LEN) begin
                        state_d = DONE;
                    end else if (dataReady) begin
                        take         = 1'b1;
                        post_count_d = post_count_q + ADDR_ONE;
                    end
                end
                DONE: begin
                    if (readDone) begin
                        if (continuous) begin
                            restart = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (restart) begin
            state_d          = PREFILL;
            wr_ptr_d         = '0;
            pre_count_d      = '0;
            post_count_d     = '0;
            timeout_d        = '0;
            auto_triggered_d = 1'b0;
        end

        if (take) begin
            write_enable_d  = 1'b1;
            write_address_d = wr_ptr_q;
            write_data_d    = dataIn;
            wr_ptr_d        = wr_ptr_q + ADDR_ONE;  // DEPTH is a power of two: natural wrap
        end

        // Status outputs are registered from the next state so that they change
        // on the same edge as the state itself.
        trigger_disable_d = (state_d != ARMED);
        capture_done_d    = (state_d == DONE);
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            wr_ptr_q          <= '0;
            pre_count_q       <= '0;
            post_count_q      <= '0;
            timeout_q         <= '0;
            write_enable_q    <= 1'b0;
            write_address_q   <= '0;
            write_data_q      <= '0;
            trigger_address_q <= '0;
            auto_triggered_q  <= 1'b0;
            trigger_disable_q <= 1'b1;
            capture_done_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            wr_ptr_q          <= wr_ptr_d;
            pre_count_q       <= pre_count_d;
            post_count_q      <= post_count_d;
            timeout_q         <= timeout_d;
            write_enable_q    <= write_enable_d;
            write_address_q   <= write_address_d;
            write_data_q      <= write_data_d;
            trigger_address_q <= trigger_address_d;
            auto_triggered_q  <= auto_triggered_d;
            trigger_disable_q <= trigger_disable_d;
            capture_done_q    <= capture_done_d;
        end
    end

    assign triggerDisable = trigger_disable_q;
    assign writeEnable    = write_enable_q;
    assign writeAddress   = write_address_q;
    assign writeData      = write_data_q;
    assign triggerAddress = trigger_address_q;
    assign autoTriggered  = auto_triggered_q;
    assign captureDone    = capture_done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
//------------------------------------------------------------------------------
// tb_capture_sequencer
//
// Self-checking bench for capture_sequencer with DEPTH=16, PRETRIGGER=4 and
// AUTO_TIMEOUT=8. A cycle table covers reset, prefill trigger masking and abort
// in POST. Hand-written sequences cover a full capture with address wrap, the
// continuous and single-shot re-arm paths, sparse samples with a stray arm, and
// the auto-trigger timeout.
//------------------------------------------------------------------------------
module tb_capture_sequencer;

    localparam int DATA_BITS    = 12;
    localparam int ADDR_BITS    = 4;
    localparam int PRETRIGGER   = 4;
    localparam int AUTO_TIMEOUT = 8;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 arm;
    logic                 abort;
    logic                 auto_mode;
    logic                 continuous;
    logic                 data_ready;
    logic [DATA_BITS-1:0] data_in;
    logic                 is_triggered;
    logic                 read_done;
    logic                 trigger_disable;
    logic                 write_enable;
    logic [ADDR_BITS-1:0] write_address;
    logic [DATA_BITS-1:0] write_data;
    logic [ADDR_BITS-1:0] trigger_address;
    logic                 auto_triggered;
    logic                 capture_done;

    int checks = 0;
    int errors = 0;

    capture_sequencer #(
        .DATA_BITS   (DATA_BITS),
        .ADDR_BITS   (ADDR_BITS),
        .PRETRIGGER  (PRETRIGGER),
        .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .autoMode      (auto_mode),
        .continuous    (continuous),
        .dataReady     (data_ready),
        .dataIn        (data_in),
        .isTriggered   (is_triggered),
        .triggerDisable(trigger_disable),
        .writeEnable   (write_enable),
        .writeAddress  (write_address),
        .writeData     (write_data),
        .triggerAddress(trigger_address),
        .autoTriggered (auto_triggered),
        .captureDone   (capture_done),
        .readDone      (read_done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then look at the registered outputs 1 ns after the edge.
    task automatic step(input logic a, input logic ab, input logic dr, input logic tr,
                        input logic rd, input logic [DATA_BITS-1:0] d);
        arm          = a;
        abort        = ab;
        data_ready   = dr;
        is_triggered = tr;
        read_done    = rd;
        data_in      = d;
        @(posedge clock);
        #1;
    endtask

    // Full capture driven with a ramp and one sample every 'gap' cycles. The
    // trigger accompanies sample 9, so the trigger point is address 10. The
    // 12-sample tail then ends on address 5 after wrapping.
    task automatic run_capture(input int gap, input bit do_arm, input bit arm_in_armed,
                               input string tag);
        int  k;
        int  nw;
        int  last_k;
        int  last_addr;
        bit  done;
        bit  present;
        bit  tr;
        bit  a;
        k         = 0;
        nw        = 0;
        last_k    = -1;
        last_addr = -1;
        done      = 1'b0;
        if (do_arm) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            check({tag, ".tdis_after_arm"}, 32'(trigger_disable), 32'd1);
        end
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            present = ((cyc % gap) == 0);
            tr      = present && (k == 9);
            a       = present && arm_in_armed && (k == 6);
            step(a, 1'b0, present, tr, 1'b0, present ? DATA_BITS'(k) : '0);
            if (present) begin
                last_k = k;
                k++;
            end
            if (write_enable) begin
                check($sformatf("%s.addr%0d", tag, nw), 32'(write_address), 32'(nw % 16));
                check($sformatf("%s.data%0d", tag, nw), 32'(write_data), 32'(nw));
                last_addr = int'(write_address);
                nw++;
            end
            check($sformatf("%s.tdis_c%0d", tag, cyc), 32'(trigger_disable),
                  (last_k >= 3 && last_k <= 8) ? 32'd0 : 32'd1);
            if (capture_done) begin
                done = 1'b1;
                check({tag, ".we_in_done"}, 32'(write_enable), 32'd0);
            end
        end
        check({tag, ".done_reached"}, 32'(done), 32'd1);
        check({tag, ".n_writes"}, 32'(nw), 32'd22);
        check({tag, ".last_addr"}, 32'(last_addr), 32'd5);
        check({tag, ".trig_addr"}, 32'(trigger_address), 32'd10);
        check({tag, ".auto_trig"}, 32'(auto_triggered), 32'd0);
    endtask

    typedef struct {
        logic                 arm;
        logic                 abort;
        logic                 dr;
        logic                 trig;
        logic [DATA_BITS-1:0] din;
        logic                 we;
        logic [ADDR_BITS-1:0] wa;
        logic [DATA_BITS-1:0] wd;
        logic                 tdis;
        logic                 cd;
        logic [ADDR_BITS-1:0] ta;
    } vec_t;

    vec_t vecs[19];

    initial begin
        //          arm ab dr tr din       we wa    wd        tdis cd ta
        vecs[0]  = '{0, 0, 0, 0, 12'h000,  0, 4'd0, 12'h000,  1,   0, 4'd0};
        vecs[1]  = '{0, 0, 1, 0, 12'h055,  0, 4'd0, 12'h000,  1,   0, 4'd0};  // sample in IDLE dropped
        vecs[2]  = '{1, 0, 0, 0, 12'h000,  0, 4'd0, 12'h000,  1,   0, 4'd0};  // arm
        vecs[3]  = '{0, 0, 1, 0, 12'h100,  1, 4'd0, 12'h100,  1,   0, 4'd0};
        vecs[4]  = '{0, 0, 1, 1, 12'h101,  1, 4'd1, 12'h101,  1,   0, 4'd0};  // trigger in PREFILL ignored
        vecs[5]  = '{0, 0, 0, 1, 12'h000,  0, 4'd1, 12'h101,  1,   0, 4'd0};
        vecs[6]  = '{0, 0, 1, 0, 12'h102,  1, 4'd2, 12'h102,  1,   0, 4'd0};
        vecs[7]  = '{0, 0, 1, 0, 12'h103,  1, 4'd3, 12'h103,  0,   0, 4'd0};  // 4th sample -> ARMED
        vecs[8]  = '{0, 0, 0, 0, 12'h000,  0, 4'd3, 12'h103,  0,   0, 4'd0};
        vecs[9]  = '{0, 0, 1, 1, 12'hFFF,  1, 4'd4, 12'hFFF,  1,   0, 4'd5};  // trigger with sample
        vecs[10] = '{0, 0, 1, 0, 12'h7FF,  1, 4'd5, 12'h7FF,  1,   0, 4'd5};
        vecs[11] = '{0, 0, 1, 0, 12'h800,  1, 4'd6, 12'h800,  1,   0, 4'd5};
        vecs[12] = '{0, 0, 1, 0, 12'h124,  1, 4'd7, 12'h124,  1,   0, 4'd5};  // 3rd post sample
        vecs[13] = '{0, 1, 1, 0, 12'h123,  0, 4'd7, 12'h124,  1,   0, 4'd5};  // abort cancels write
        vecs[14] = '{0, 0, 1, 0, 12'h001,  0, 4'd7, 12'h124,  1,   0, 4'd5};
        vecs[15] = '{1, 1, 0, 0, 12'h000,  0, 4'd7, 12'h124,  1,   0, 4'd5};  // abort beats arm
        vecs[16] = '{0, 0, 1, 0, 12'h002,  0, 4'd7, 12'h124,  1,   0, 4'd5};
        vecs[17] = '{1, 0, 0, 0, 12'h000,  0, 4'd7, 12'h124,  1,   0, 4'd5};
        vecs[18] = '{0, 0, 1, 0, 12'h0AA,  1, 4'd0, 12'h0AA,  1,   0, 4'd5};  // wrPtr restarts at 0

        reset      = 1'b1;
        auto_mode  = 1'b0;
        continuous = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'hABC);  // reset dominates everything
        check("reset.tdis", 32'(trigger_disable), 32'd1);
        check("reset.we",   32'(write_enable),    32'd0);
        check("reset.wa",   32'(write_address),   32'd0);
        check("reset.wd",   32'(write_data),      32'd0);
        check("reset.ta",   32'(trigger_address), 32'd0);
        check("reset.at",   32'(auto_triggered),  32'd0);
        check("reset.cd",   32'(capture_done),    32'd0);
        reset = 1'b0;

        // Table: prefill masking, abort after three post samples, abort vs arm.
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].arm, vecs[i].abort, vecs[i].dr, vecs[i].trig, 1'b0, vecs[i].din);
            check($sformatf("vec%0d.we", i),   32'(write_enable),    32'(vecs[i].we));
            check($sformatf("vec%0d.wa", i),   32'(write_address),   32'(vecs[i].wa));
            check($sformatf("vec%0d.wd", i),   32'(write_data),      32'(vecs[i].wd));
            check($sformatf("vec%0d.tdis", i), 32'(trigger_disable), 32'(vecs[i].tdis));
            check($sformatf("vec%0d.cd", i),   32'(capture_done),    32'(vecs[i].cd));
            check($sformatf("vec%0d.ta", i),   32'(trigger_address), 32'(vecs[i].ta));
            check($sformatf("vec%0d.at", i),   32'(auto_triggered),  32'd0);
        end

        // Full capture with a sample every cycle, starting from reset.
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        reset = 1'b0;
        run_capture(1, 1'b1, 1'b0, "t1");

        // Continuous re-arm goes straight back to PREFILL with wrPtr cleared.
        continuous = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("t4.cd_drop_cont", 32'(capture_done),    32'd0);
        check("t4.tdis_cont",    32'(trigger_disable), 32'd1);
        continuous = 1'b0;

        // Sparse samples and a stray arm while ARMED: same addresses as before.
        run_capture(3, 1'b0, 1'b1, "t6");

        // Single-shot readDone returns to IDLE, where samples are dropped.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("t4.cd_drop_single", 32'(capture_done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, DATA_BITS'(i));
            check($sformatf("t4.idle_we%0d", i),   32'(write_enable),    32'd0);
            check($sformatf("t4.idle_tdis%0d", i), 32'(trigger_disable), 32'd1);
        end

        // Auto trigger: 8 armed samples, then the timeout fires with sample 12.
        // The second pass puts a real trigger on that same cycle.
        auto_mode = 1'b1;
        for (int run = 0; run < 2; run++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
            for (int k = 0; k < 13; k++) begin
                step(1'b0, 1'b0, 1'b1, (run == 1) && (k == 12), 1'b0, DATA_BITS'(k));
                if (k == 11) begin
                    check($sformatf("t3.r%0d.no_early_fire", run), 32'(trigger_disable), 32'd0);
                end
            end
            check($sformatf("t3.r%0d.we", run),   32'(write_enable),    32'd1);
            check($sformatf("t3.r%0d.wa", run),   32'(write_address),   32'd12);
            check($sformatf("t3.r%0d.ta", run),   32'(trigger_address), 32'd13);
            check($sformatf("t3.r%0d.at", run),   32'(auto_triggered),  (run == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3.r%0d.tdis", run), 32'(trigger_disable), 32'd1);
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h3C3);
            check($sformatf("t3.r%0d.abort_we", run),   32'(write_enable),    32'd0);
            check($sformatf("t3.r%0d.abort_cd", run),   32'(capture_done),    32'd0);
            check($sformatf("t3.r%0d.abort_tdis", run), 32'(trigger_disable), 32'd1);
        end
        auto_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
